// File: rtl/calc_pkg.sv
// Shared opcode map, flag bit positions and opcode classification for the
// pipelined register-file calculator.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_ADC = 4'b1110;
  localparam logic [3:0] OP_RSV = 4'b1111;

  // Bit positions inside the registered flag vector
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  // Opcodes that produce Carry and Overflow; all others leave them untouched
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/pipelined_calculator_if.sv
// Instruction/result bundle of the pipelined calculator. The master side
// issues instructions, the slave side (the calculator) returns results.
interface pipelined_calculator_if #(
  parameter int DATA_W  = 8,
  parameter int REG_NUM = 8
);
  localparam int ADDR_W = $clog2(REG_NUM);

  logic              InValid;
  logic              InReady;
  logic              WEN;
  logic [ADDR_W-1:0] RW;
  logic [ADDR_W-1:0] RX;
  logic [ADDR_W-1:0] RY;
  logic [DATA_W-1:0] DataIn;
  logic              Sel;
  logic [3:0]        Ctrl;
  logic              OutValid;
  logic [DATA_W-1:0] Result;
  logic              Carry;
  logic              Zero;
  logic              Overflow;

  modport master (
    output InValid, WEN, RW, RX, RY, DataIn, Sel, Ctrl,
    input  InReady, OutValid, Result, Carry, Zero, Overflow
  );

  modport slave (
    input  InValid, WEN, RW, RX, RY, DataIn, Sel, Ctrl,
    output InReady, OutValid, Result, Carry, Zero, Overflow
  );
endinterface

// File: rtl/calc_alu.sv
// Single-cycle combinational ALU covering every opcode except MUL.
// Produces the result plus carry-out and signed overflow for ADD/SUB/ADC.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] res,
  output logic              cout,
  output logic              ovf
);
  localparam int SH = $clog2(DATA_W);

  logic signed [DATA_W-1:0] a_s;
  logic        [DATA_W:0]   sum;
  logic        [DATA_W-1:0] b_eff;
  logic                     cin_eff;

  assign a_s = a;

  // Opcode decode; SUB is folded into the adder as A + ~B + 1
  always_comb begin
    res     = '0;
    cout    = 1'b0;
    ovf     = 1'b0;
    b_eff   = b;
    cin_eff = 1'b0;
    sum     = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC: begin
        b_eff   = (op == OP_SUB) ? ~b : b;
        cin_eff = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? cin : 1'b0);
        sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_eff};
        res     = sum[DATA_W-1:0];
        cout    = sum[DATA_W];
        ovf     = (a[DATA_W-1] == b_eff[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOT: res = ~a;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SHL: res = b << a[SH-1:0];
      OP_SHR: res = b >> a[SH-1:0];
      OP_ASR: res = a_s >>> 1;
      OP_ROL: res = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_ROR: res = {a[0], a[DATA_W-1:1]};
      OP_EQ:  res = {{(DATA_W-1){1'b0}}, (a == b)};
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/pipelined_calculator.sv
// Register-file calculator with an operand-read stage feeding one execute
// stage (S1). Single-cycle ops complete one edge after acceptance; MUL
// iterates shift-add for DATA_W cycles in S1 and stalls the front end.
module pipelined_calculator
  import calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_NUM = 8
) (
  input  logic Clk,
  input  logic Rst,
  pipelined_calculator_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_NUM);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] rf [REG_NUM];

  logic              vld_p1;
  logic [3:0]        op_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              wen_p1;
  logic [ADDR_W-1:0] rw_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [DATA_W-1:0] acc_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] res_p2;
  logic [FLAG_N-1:0] flags_p2;

  logic              accept;
  logic              complete;
  logic              fwd_en;
  logic              is_mul_p1;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [DATA_W-1:0] mul_sum;
  logic [DATA_W-1:0] exec_res;

  assign is_mul_p1   = (op_p1 == OP_MUL);
  assign bus.InReady = ~(vld_p1 & is_mul_p1 & (cnt_p1 != CNT_LAST));
  assign accept      = bus.InValid & bus.InReady;
  assign complete    = vld_p1 & (~is_mul_p1 | (cnt_p1 == CNT_LAST));
  assign fwd_en      = complete & wen_p1 & (rw_p1 != '0);

  // One partial product per cycle; the last step feeds completion directly
  assign mul_sum  = acc_p1 + (b_p1[cnt_p1] ? (a_p1 << cnt_p1) : '0);
  assign exec_res = is_mul_p1 ? mul_sum : alu_res;

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (op_p1),
    .a    (a_p1),
    .b    (b_p1),
    .cin  (flags_p2[FLAG_C]),
    .res  (alu_res),
    .cout (alu_c),
    .ovf  (alu_v)
  );

  // ---- stage p0: operand read with forwarding of the completing result ----
  always_comb begin
    opb = rf[bus.RY];
    if (bus.RY == '0)
      opb = '0;
    else if (fwd_en && (bus.RY == rw_p1))
      opb = exec_res;

    opa = rf[bus.RX];
    if (bus.RX == '0)
      opa = '0;
    else if (fwd_en && (bus.RX == rw_p1))
      opa = exec_res;
    if (!bus.Sel)
      opa = bus.DataIn;
  end

  // ---- stage p1: execute-stage occupancy and MUL step counter ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      cnt_p1 <= '0;
    end else if (complete) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (vld_p1 && is_mul_p1) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // Execute-stage operands and MUL accumulator; qualified by vld_p1
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_p1  <= bus.Ctrl;
      a_p1   <= opa;
      b_p1   <= opb;
      wen_p1 <= bus.WEN;
      rw_p1  <= bus.RW;
      acc_p1 <= '0;
    end else if (vld_p1 && is_mul_p1 && !complete) begin
      acc_p1 <= mul_sum;
    end
  end

  // ---- stage p2: writeback, result and flag registers ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
      vld_p2   <= 1'b0;
      res_p2   <= '0;
      flags_p2 <= '0;
    end else begin
      vld_p2 <= complete;
      if (complete) begin
        res_p2           <= exec_res;
        flags_p2[FLAG_Z] <= (exec_res == '0);
        if (is_arith(op_p1)) begin
          flags_p2[FLAG_C] <= alu_c;
          flags_p2[FLAG_V] <= alu_v;
        end
      end
      if (fwd_en)
        rf[rw_p1] <= exec_res;
    end
  end

  assign bus.OutValid = vld_p2;
  assign bus.Result   = res_p2;
  assign bus.Carry    = flags_p2[FLAG_C];
  assign bus.Zero     = flags_p2[FLAG_Z];
  assign bus.Overflow = flags_p2[FLAG_V];
endmodule

// File: doc/pipelined_calculator.md
# pipelined_calculator

Parametrised successor of the 8-bit single-cycle register-file calculator. It holds a DATA_W-wide, REG_NUM-entry register file (R0 hard-wired to zero) and a two-stage operand-read/execute pipeline with one-path result forwarding. Beyond the single-cycle operation set, it adds a valid/ready instruction handshake, an iterative multi-cycle multiply, add-with-carry, and a registered Carry/Zero/Overflow flag set. It sits in the same datapath slot as the single-cycle calculator.

## Interface
- DATA_W, 8, operand/register width (≥4)
- REG_NUM, 8, register count (power of two, ≥2); ADDR_W = $clog2(REG_NUM)
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- InValid  in  1  instruction present
- InReady  out  1  block can accept; accept = InValid & InReady at rising Clk
- WEN  in  1  write result to RF[RW] on completion
- RW, RX, RY  in  ADDR_W  write / operand-A / operand-B register indices
- DataIn  in  DATA_W  immediate operand
- Sel  in  1  A source: 0 = DataIn, 1 = RF[RX]
- Ctrl  in  4  opcode
- OutValid  out  1  Result/flags valid, one-cycle pulse per completed instruction
- Result  out  DATA_W  last completed result (held)
- Carry, Zero, Overflow  out  1  registered flags

## Operation
- Accept samples all inputs. Operand B is RF[RY]. Operand A is selected by Sel. Operands are captured into the execute stage (S1).
- Opcodes (A, B):
  - 0000 ADD A+B
  - 0001 SUB A−B
  - 0010 AND
  - 0011 OR
  - 0100 NOT A
  - 0101 XOR
  - 0110 NOR
  - 0111 B << A[SH−1:0]
  - 1000 B >> A[SH−1:0] (logical; SH = $clog2(DATA_W))
  - 1001 arithmetic shift right A by 1
  - 1010 rotate left A by 1
  - 1011 rotate right A by 1
  - 1100 EQ (1 if A==B else 0)
  - 1101 MUL (unsigned, low DATA_W bits)
  - 1110 ADC A+B+Carry
  - 1111 reserved: result 0
- Width and flag rules:
  - All arithmetic is DATA_W-bit modulo.
  - Carry = carry-out of A+B (ADD), A+~B+1 (SUB; 1 = no borrow), A+B+Carry (ADC). Other ops leave Carry unchanged.
  - Overflow = signed two's-complement overflow on ADD/SUB/ADC. Other ops leave Overflow unchanged.
  - Zero = (Result==0), updated on every completion.
- MUL: shift-add, one partial-product step per cycle, DATA_W cycles in S1. A cycle counter runs 0..DATA_W−1.
- Writeback: on completion, if WEN & RW≠0 then RF[RW] ← result. Writes to R0 are discarded. Reads of R0 always return 0.
- Forwarding: an instruction accepted at the edge where S1 completes reads RF before that write lands. For RX/RY equal to the completing RW (WEN=1, RW≠0), the ALU output is forwarded instead. WEN=0 completions never forward.
- InReady = ~(S1 valid & MUL & counter≠DATA_W−1). It is combinational from state only, never from InValid.
- Reset: all RF entries, Result, Carry, Zero, Overflow, OutValid = 0; S1 empty; counter = 0; InReady = 1. Rst during a MUL aborts it with no writeback and no OutValid.

## Timing
- Non-MUL accepted at edge k: writeback, Result, flags, and OutValid at edge k+1. Sustained throughput is 1 instruction/cycle.
- MUL accepted at edge k: InReady low for cycles k..k+DATA_W−2. Completion occurs at edge k+DATA_W. A new instruction may be accepted at that same edge.
- While InReady=0, InValid may stay high. Nothing is accepted and the inputs are not sampled.
- OutValid is high exactly one cycle per completion. Result and flags hold until the next completion.
- No combinational path from DataIn/Ctrl to outputs.

## Structure
- Package calc_pkg:
  - opcode localparams (OP_ADD … OP_RSV)
  - flag index constants
  - is_arith(opcode) helper
- Sub-module calc_alu: purely combinational single-cycle ALU. It computes result, carry, and overflow for all non-MUL opcodes, parametrised by DATA_W.
- Top level holds the RF, S1 registers, MUL datapath/counter, forwarding muxes, and flag registers.

## Test plan
(DATA_W=8, REG_NUM=8)
- Reset:
  - Rst pulse → Result=0x00, all flags 0, OutValid=0, InReady=1.
  - ADD Sel=1 RX=7 RY=3 → Result 0x00, Zero=1.
- Forwarding with overflow:
  - ADD DataIn=0x7F RY=0 WEN RW=1, back-to-back with ADD DataIn=0x01 RY=1 → second Result 0x80, Overflow=1, Carry=0.
- Subtract and flags:
  - R1=0x05; SUB DataIn=0x03 RY=1 → 0xFE, Carry=0, Zero=0.
  - SUB DataIn=0x05 RY=1 → 0x00, Carry=1, Zero=1.
- Multiply stall:
  - R2=0x0B; MUL DataIn=0x0D RY=2 accepted at edge k, InValid held high → InReady low 7 cycles, OutValid only at edge k+8, Result 0x8F.
  - Next instruction accepted at edge k+8.
- ADC chain and R0 discard:
  - ADD 0xFF+0x01 → 0x00, Carry=1.
  - ADC 0x00+R0 → 0x01, Carry=0.
  - WEN RW=0 followed by a read of R0 → 0x00.
- Reset mid-operation:
  - Rst asserted 3 cycles into a MUL with RW=4 → no OutValid, R4 reads 0x00, InReady=1 immediately.
